// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR write unit.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } state_t;

  localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TMR = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIE_MEIE     = 11;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_alu.sv
// Combinational read-modify-write value and write-intent for CSRRW/RS/RC(I).
module csr_alu
  import csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic [31:0] old,
  output logic [31:0] new_val,
  output logic        wr_intent
);

  logic [31:0] src;

  // Select operand and compute the updated CSR value.
  always_comb begin
    src       = funct3[2] ? {27'b0, rs1_idx} : rs1_data;
    new_val   = old;
    wr_intent = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: begin
        new_val   = src;
        wr_intent = 1'b1;
      end
      F3_RS, F3_RSI: begin
        new_val   = old | src;
        wr_intent = (rs1_idx != '0);
      end
      F3_RC, F3_RCI: begin
        new_val   = old & ~src;
        wr_intent = (rs1_idx != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_write_unit.sv
// Machine-mode CSR write side: CSR ops in EX, interrupt entry, MRET and WFI sleep.
module csr_write_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter bit          IRQ_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        csr_valid,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic [31:0] pc,
  input  logic        mret,
  input  logic        wfi,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wfi_sleep
);

  state_t      state, state_nxt;
  logic        st_mie, st_mpie, ie_meie, ie_mtie;
  logic [31:0] mtvec_q, mepc_q, mcause_q, wake_pc;
  logic [31:0] mstatus_rd, mie_rd, mip_rd, old_val, new_val, trap_pc;
  logic        impl, ro_space, wr_intent;
  logic        ext_hit, irq_src, irq_pend, run_go, take_trap, commit, illegal, wr_en;
  logic        mret_go, wfi_go, wake, trap_sleep, trap_any;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mie_rd     = {20'b0, ie_meie, 3'b0, ie_mtie, 7'b0};
  assign mip_rd     = {20'b0, ext_irq, 3'b0, tmr_irq, 7'b0};

  // Current CSR value and whether the address is implemented here.
  always_comb begin
    impl    = 1'b1;
    old_val = '0;
    case (csr_addr)
      ADDR_MSTATUS: old_val = mstatus_rd;
      ADDR_MIE:     old_val = mie_rd;
      ADDR_MTVEC:   old_val = mtvec_q;
      ADDR_MEPC:    old_val = mepc_q;
      ADDR_MCAUSE:  old_val = mcause_q;
      ADDR_MIP:     old_val = mip_rd;
      default:      impl    = 1'b0;
    endcase
  end

  csr_alu u_alu (
    .funct3    (funct3),
    .rs1_idx   (rs1_idx),
    .rs1_data  (rs1_data),
    .old       (old_val),
    .new_val   (new_val),
    .wr_intent (wr_intent)
  );

  // Interrupt qualification shared by RUN (trap) and SLEEP (wake) handling;
  // wake ignores the global MIE, trap entry needs it.
  assign ext_hit    = ie_meie & ext_irq;
  assign irq_src    = IRQ_EN & (ext_hit | (ie_mtie & tmr_irq));
  assign irq_pend   = irq_src & st_mie;
  assign run_go     = (state == RUN) & ~stall;
  assign take_trap  = run_go & irq_pend;
  assign commit     = csr_valid & run_go & ~take_trap;
  assign mret_go    = mret & run_go & ~take_trap;
  assign wfi_go     = wfi & run_go & ~take_trap;
  assign wake       = (state == SLEEP) & irq_src;
  assign trap_sleep = wake & st_mie;
  assign trap_any   = take_trap | trap_sleep;
  assign trap_pc    = take_trap ? pc : wake_pc;

  assign ro_space = (csr_addr[11:10] == 2'b11);
  assign illegal  = commit & (ro_space ? wr_intent : ~impl);
  assign wr_en    = commit & ~illegal & ~ro_space & wr_intent;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state and sleep indication.
  always_comb begin
    state_nxt = state;
    wfi_sleep = 1'b0;
    case (state)
      RUN: begin
        if (wfi_go) state_nxt = SLEEP;
      end
      SLEEP: begin
        wfi_sleep = 1'b1;
        if (wake) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // CSR storage: trap entry beats MRET, which beats a CSR write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      ie_meie  <= 1'b0;
      ie_mtie  <= 1'b0;
      mtvec_q  <= MTVEC_RST & ALIGN_MASK;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_any) begin
      mepc_q   <= trap_pc & ALIGN_MASK;
      mcause_q <= ext_hit ? MCAUSE_EXT : MCAUSE_TMR;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else if (mret_go) begin
      st_mie   <= st_mpie;
      st_mpie  <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          st_mie  <= new_val[MSTATUS_MIE];
          st_mpie <= new_val[MSTATUS_MPIE];
        end
        ADDR_MIE: begin
          ie_meie <= new_val[MIE_MEIE];
          ie_mtie <= new_val[MIE_MTIE];
        end
        ADDR_MTVEC:  mtvec_q  <= new_val & ALIGN_MASK;
        ADDR_MEPC:   mepc_q   <= new_val & ALIGN_MASK;
        ADDR_MCAUSE: mcause_q <= new_val;
        default: ;
      endcase
    end
  end

  // Return address captured when entering sleep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wake_pc <= '0;
    else if (wfi_go) wake_pc <= pc + 32'd4;
  end

  // Registered result, illegal pulse and fetch redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      csr_rdata   <= (commit & ~illegal & ~ro_space) ? old_val : '0;
      csr_illegal <= illegal;
      redirect    <= trap_any | mret_go;
      redirect_pc <= trap_any ? mtvec_q : (mret_go ? mepc_q : '0);
    end
  end

endmodule

// File: tb/tb_csr_write_unit.sv
// Self-checking bench for csr_write_unit: directed scenarios plus a randomized
// CSR-op sequence checked against an architectural model.
module tb_csr_write_unit;

  localparam logic [31:0] TVEC_RST = 32'h0000_0403;

  logic        clk = 1'b0;
  logic        rst, stall, csr_valid, mret, wfi, ext_irq, tmr_irq;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data, pc;
  logic [31:0] csr_rdata, redirect_pc;
  logic        csr_illegal, redirect, wfi_sleep;

  int errors = 0;
  int checks = 0;

  csr_write_unit #(.MTVEC_RST(TVEC_RST), .IRQ_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .csr_valid(csr_valid), .funct3(funct3),
    .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data), .pc(pc),
    .mret(mret), .wfi(wfi), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .redirect(redirect),
    .redirect_pc(redirect_pc), .wfi_sleep(wfi_sleep)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                        input logic [31:0] d, output logic [31:0] rd, output logic ill);
    funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d; csr_valid = 1'b1;
    @(posedge clk); #1;
    rd = csr_rdata; ill = csr_illegal;
    csr_valid = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
    logic ill;
    csr_op(3'b010, a, 5'd0, 32'd0, v, ill);
  endtask

  task automatic apply_reset();
    rst = 1'b1; stall = 1'b0; csr_valid = 1'b0; mret = 1'b0; wfi = 1'b0;
    ext_irq = 1'b0; tmr_irq = 1'b0; funct3 = '0; csr_addr = '0; rs1_idx = '0;
    rs1_data = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    apply_reset();
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", csr_rdata); end
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", csr_illegal); end
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect, redirect_pc); end
    checks++; if (wfi_sleep !== 1'b0) begin errors++; $display("FAIL reset_sleep got=%b exp=0", wfi_sleep); end
    rst = 1'b0;
    csr_read(12'h300, v);
    checks++; if (v !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus got=%h exp=00001800", v); end
    csr_read(12'h305, v);
    checks++; if (v !== (TVEC_RST & ~32'd3)) begin errors++; $display("FAIL reset_mtvec got=%h exp=%h", v, TVEC_RST & ~32'd3); end
    csr_read(12'h304, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_mie got=%h exp=0", v); end
    csr_read(12'h342, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_mcause got=%h exp=0", v); end
  endtask

  task automatic test_rw_basic();
    logic [31:0] v;
    logic ill;
    csr_op(3'b001, 12'h305, 5'd3, 32'h0000_1003, v, ill);
    checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL rw_old got=%h exp=00000400", v); end
    csr_op(3'b010, 12'h305, 5'd0, 32'hFFFF_FFFF, v, ill);
    checks++; if (v !== 32'h0000_1000) begin errors++; $display("FAIL rs0_mtvec got=%h exp=00001000", v); end
  endtask

  task automatic test_rc_imm();
    logic [31:0] v;
    logic ill;
    csr_op(3'b001, 12'h300, 5'd1, 32'h0000_1888, v, ill);
    csr_op(3'b111, 12'h300, 5'd8, 32'hFFFF_FFFF, v, ill);
    checks++; if (v !== 32'h0000_1888) begin errors++; $display("FAIL rci_old got=%h exp=00001888", v); end
    csr_read(12'h300, v);
    checks++; if (v !== 32'h0000_1880) begin errors++; $display("FAIL rci_new got=%h exp=00001880", v); end
    csr_op(3'b001, 12'h300, 5'd1, 32'd0, v, ill);
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    logic ill;
    csr_op(3'b001, 12'hC00, 5'd2, 32'h0000_0055, v, ill);
    checks++; if (ill !== 1'b1 || v !== 32'd0) begin errors++; $display("FAIL ro_write got=%b/%h exp=1/0", ill, v); end
    @(posedge clk); #1;
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse got=%b exp=0", csr_illegal); end
    csr_op(3'b001, 12'h305, 5'd0, 32'h0000_1000, v, ill);
    csr_op(3'b101, 12'hC00, 5'd0, 32'd0, v, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL ro_rwi_zero got=%b exp=1", ill); end
    csr_read(12'h305, v);
    checks++; if (v !== 32'h0000_1000) begin errors++; $display("FAIL ro_nochange got=%h exp=00001000", v); end
    csr_op(3'b010, 12'hC00, 5'd0, 32'd0, v, ill);
    checks++; if (ill !== 1'b0 || v !== 32'd0) begin errors++; $display("FAIL ro_read got=%b/%h exp=0/0", ill, v); end
    csr_op(3'b010, 12'h7C0, 5'd0, 32'd0, v, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL unimpl got=%b exp=1", ill); end
    csr_op(3'b001, 12'h344, 5'd1, 32'hFFFF_FFFF, v, ill);
    csr_read(12'h344, v);
    checks++; if (ill !== 1'b0 || v !== 32'd0) begin errors++; $display("FAIL mip_ro got=%b/%h exp=0/0", ill, v); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                12'h344, 12'hC00, 12'hF14, 12'h7C0, 12'h301};
    logic [2:0]  f3s [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [31:0] ms, mi, tv, ep, mc;
    logic [31:0] src, nv, old, exp_rd, v;
    logic [11:0] a;
    logic [2:0]  f;
    logic [4:0]  idx;
    logic [31:0] d;
    logic        wr, known, exp_ill, ill;
    apply_reset();
    rst = 1'b0;
    ms = 32'h0000_1800; mi = 0; tv = TVEC_RST & ~32'd3; ep = 0; mc = 0;
    for (int i = 0; i < 60; i++) begin
      a = addrs[$urandom_range(0, 9)];
      f = f3s[$urandom_range(0, 5)];
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      d = $urandom;
      src = f[2] ? {27'd0, idx} : d;
      wr = (f == 3'd1 || f == 3'd5) || (idx != 0);
      known = 1'b1; old = 0;
      case (a)
        12'h300: old = ms;
        12'h304: old = mi;
        12'h305: old = tv;
        12'h341: old = ep;
        12'h342: old = mc;
        12'h344: old = 0;
        default: known = 1'b0;
      endcase
      exp_ill = 1'b0; exp_rd = 0;
      if (a >= 12'hC00) exp_ill = wr;
      else if (!known) exp_ill = 1'b1;
      else begin
        exp_rd = old;
        if (wr) begin
          if (f == 3'd1 || f == 3'd5) nv = src;
          else if (f == 3'd2 || f == 3'd6) nv = old | src;
          else nv = old & ~src;
          case (a)
            12'h300: ms = 32'h0000_1800 | (nv & 32'h0000_0088);
            12'h304: mi = nv & 32'h0000_0880;
            12'h305: tv = nv & ~32'd3;
            12'h341: ep = nv & ~32'd3;
            12'h342: mc = nv;
            default: ;
          endcase
        end
      end
      csr_op(f, a, idx, d, v, ill);
      checks++; if (v !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr=%h f3=%0d got=%h exp=%h", i, a, f, v, exp_rd); end
      checks++; if (ill !== exp_ill) begin errors++; $display("FAIL rand_illegal[%0d] addr=%h f3=%0d got=%b exp=%b", i, a, f, ill, exp_ill); end
    end
  endtask

  task automatic test_trap();
    logic [31:0] v;
    logic ill;
    csr_op(3'b001, 12'h305, 5'd1, 32'h0000_1000, v, ill);
    csr_op(3'b001, 12'h304, 5'd1, 32'h0000_0800, v, ill);
    csr_op(3'b001, 12'h300, 5'd1, 32'h0000_0088, v, ill);
    pc = 32'h0000_0200; ext_irq = 1'b1;
    funct3 = 3'b001; csr_addr = 12'h305; rs1_idx = 5'd1; rs1_data = 32'hDEAD_BEE0; csr_valid = 1'b1;
    @(posedge clk); #1;
    csr_valid = 1'b0; ext_irq = 1'b0;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h0000_1000) begin errors++; $display("FAIL trap_redirect got=%b/%h exp=1/00001000", redirect, redirect_pc); end
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL trap_drop_rdata got=%h exp=0", csr_rdata); end
    @(posedge clk); #1;
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'd0) begin errors++; $display("FAIL trap_pulse got=%b/%h exp=0/0", redirect, redirect_pc); end
    csr_read(12'h341, v);
    checks++; if (v !== 32'h0000_0200) begin errors++; $display("FAIL trap_mepc got=%h exp=00000200", v); end
    csr_read(12'h342, v);
    checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL trap_mcause got=%h exp=8000000b", v); end
    csr_read(12'h300, v);
    checks++; if (v !== 32'h0000_1880) begin errors++; $display("FAIL trap_mstatus got=%h exp=00001880", v); end
    csr_read(12'h305, v);
    checks++; if (v !== 32'h0000_1000) begin errors++; $display("FAIL trap_mtvec got=%h exp=00001000", v); end
  endtask

  task automatic test_mret_stall();
    logic [31:0] v;
    logic ill;
    stall = 1'b1;
    csr_op(3'b001, 12'h305, 5'd1, 32'h0000_2000, v, ill);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL stall_rdata got=%h exp=0", v); end
    mret = 1'b1;
    @(posedge clk); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mret_stalled got=%b exp=0", redirect); end
    stall = 1'b0;
    @(posedge clk); #1;
    mret = 1'b0;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0200) begin errors++; $display("FAIL mret_redirect got=%b/%h exp=1/00000200", redirect, redirect_pc); end
    csr_read(12'h300, v);
    checks++; if (v !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got=%h exp=00001888", v); end
    csr_read(12'h305, v);
    checks++; if (v !== 32'h0000_1000) begin errors++; $display("FAIL stall_mtvec got=%h exp=00001000", v); end
  endtask

  task automatic test_wfi();
    logic [31:0] v;
    logic ill;
    csr_op(3'b001, 12'h304, 5'd1, 32'h0000_0080, v, ill);
    csr_op(3'b111, 12'h300, 5'd8, 32'd0, v, ill);
    // MIE=0: sleep, ignore a masked ext_irq, wake on tmr_irq without redirect
    pc = 32'h0000_0100; wfi = 1'b1;
    @(posedge clk); #1;
    wfi = 1'b0; ext_irq = 1'b1;
    checks++; if (wfi_sleep !== 1'b1) begin errors++; $display("FAIL wfi_enter got=%b exp=1", wfi_sleep); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (wfi_sleep !== 1'b1 || redirect !== 1'b0) begin errors++; $display("FAIL wfi_hold[%0d] got=%b/%b exp=1/0", i, wfi_sleep, redirect); end
    end
    ext_irq = 1'b0; tmr_irq = 1'b1;
    @(posedge clk); #1;
    tmr_irq = 1'b0;
    checks++; if (wfi_sleep !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL wfi_wake_nomie got=%b/%b exp=0/0", wfi_sleep, redirect); end
    // MIE=1: wake becomes a trap with mepc=pc+4
    csr_op(3'b110, 12'h300, 5'd8, 32'd0, v, ill);
    wfi = 1'b1;
    @(posedge clk); #1;
    wfi = 1'b0; tmr_irq = 1'b1;
    @(posedge clk); #1;
    tmr_irq = 1'b0;
    checks++; if (wfi_sleep !== 1'b0 || redirect !== 1'b1 || redirect_pc !== 32'h0000_1000) begin errors++; $display("FAIL wfi_trap got=%b/%b/%h exp=0/1/00001000", wfi_sleep, redirect, redirect_pc); end
    csr_read(12'h341, v);
    checks++; if (v !== 32'h0000_0104) begin errors++; $display("FAIL wfi_mepc got=%h exp=00000104", v); end
    csr_read(12'h342, v);
    checks++; if (v !== 32'h8000_0007) begin errors++; $display("FAIL wfi_mcause got=%h exp=80000007", v); end
    csr_read(12'h300, v);
    checks++; if (v !== 32'h0000_1880) begin errors++; $display("FAIL wfi_mstatus got=%h exp=00001880", v); end
    // wake_pc wrap and external-over-timer priority
    csr_op(3'b001, 12'h304, 5'd1, 32'h0000_0880, v, ill);
    csr_op(3'b110, 12'h300, 5'd8, 32'd0, v, ill);
    pc = 32'hFFFF_FFFC; wfi = 1'b1;
    @(posedge clk); #1;
    wfi = 1'b0; ext_irq = 1'b1; tmr_irq = 1'b1;
    @(posedge clk); #1;
    ext_irq = 1'b0; tmr_irq = 1'b0;
    csr_read(12'h341, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL wrap_mepc got=%h exp=0", v); end
    csr_read(12'h342, v);
    checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL prio_mcause got=%h exp=8000000b", v); end
    // asynchronous reset while sleeping
    pc = 32'h0000_0100; wfi = 1'b1;
    @(posedge clk); #1;
    wfi = 1'b0;
    checks++; if (wfi_sleep !== 1'b1) begin errors++; $display("FAIL rst_pre_sleep got=%b exp=1", wfi_sleep); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wfi_sleep !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL rst_sleep got=%b/%b exp=0/0", wfi_sleep, redirect); end
    @(posedge clk); #1;
    rst = 1'b0;
    csr_read(12'h305, v);
    checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL rst_mtvec got=%h exp=00000400", v); end
  endtask

  initial begin
    test_reset();
    test_rw_basic();
    test_rc_imm();
    test_illegal();
    test_random();
    test_trap();
    test_mret_stall();
    test_wfi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
